// File: rtl/mmio_io_fifo.sv
// CPU-side MMIO block: LEDs, TX/RX byte FIFOs around UART bit engines, and a status register.
// Reads answer one cycle after the request, matching the RAM on the same port.
module mmio_uart_tx #(
  parameter int CPB = 5208
) (
  input  logic       clk_cpu,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] data,
  output logic       bsy,
  output logic       tx
);
  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;

  logic          busy_q, done_q, tx_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cnt_q;
  logic [8:0]    sh_q;

  // done_q blocks a restart until go has been dropped for this character
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tx_q   <= 1'b1;
      bit_q  <= '0;
      cnt_q  <= '0;
      sh_q   <= '1;
    end else begin
      if (!go) done_q <= 1'b0;
      if (!busy_q) begin
        if (go && !done_q) begin
          busy_q <= 1'b1;
          sh_q   <= {1'b1, data};
          bit_q  <= '0;
          cnt_q  <= CW'(CPB - 1);
          tx_q   <= 1'b0;
        end
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        bit_q <= bit_q + 1'b1;
        cnt_q <= CW'(CPB - 1);
        tx_q  <= sh_q[0];
        sh_q  <= {1'b1, sh_q[8:1]};
      end
    end
  end

  assign bsy = busy_q;
  assign tx  = tx_q;
endmodule

module mmio_uart_rx #(
  parameter int CPB = 5208
) (
  input  logic       clk_cpu,
  input  logic       rst,
  input  logic       rx,
  input  logic       go,
  output logic       dr,
  output logic [7:0] data
);
  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;

  logic [1:0]    sync_q;
  logic          busy_q, dr_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    sh_q, data_q;

  // First sample lands mid start bit, then one sample per bit period
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      sync_q <= 2'b11;
      busy_q <= 1'b0;
      dr_q   <= 1'b0;
      bit_q  <= '0;
      cnt_q  <= '0;
      sh_q   <= '0;
      data_q <= '0;
    end else begin
      sync_q <= {sync_q[0], rx};
      if (!go) dr_q <= 1'b0;
      if (!busy_q) begin
        if (!sync_q[1]) begin
          busy_q <= 1'b1;
          cnt_q  <= CW'(CPB / 2);
          bit_q  <= '0;
        end
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        cnt_q <= CW'(CPB - 1);
        bit_q <= bit_q + 1'b1;
        if (bit_q == 4'd0 && sync_q[1]) begin
          busy_q <= 1'b0;
        end else if (bit_q >= 4'd1 && bit_q <= 4'd8) begin
          sh_q <= {sync_q[1], sh_q[7:1]};
        end else if (bit_q == 4'd9) begin
          busy_q <= 1'b0;
          data_q <= sh_q;
          dr_q   <= 1'b1;
        end
      end
    end
  end

  assign dr   = dr_q;
  assign data = data_q;
endmodule

module mmio_io_fifo #(
  parameter int          CLK_FREQ               = 50_000_000,
  parameter int          BAUD_RATE              = 9600,
  parameter logic [31:0] TOP_ADDR               = 32'hFFFF_FFFF,
  parameter int          LED_WIDTH              = 6,
  parameter int          TX_FIFO_DEPTH_BITWIDTH = 4,
  parameter int          RX_FIFO_DEPTH_BITWIDTH = 4
) (
  input  logic                 clk_cpu,
  input  logic                 rst,
  input  logic [2:0]           re,
  input  logic [1:0]           we,
  input  logic [31:0]          addr,
  input  logic [31:0]          din,
  output logic [31:0]          dout,
  output logic                 hit,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 rx_ready,
  output logic                 uart_tx,
  input  logic                 uart_rx
);
  localparam int          CPB    = CLK_FREQ / BAUD_RATE;
  localparam int          TXB    = TX_FIFO_DEPTH_BITWIDTH;
  localparam int          RXB    = RX_FIFO_DEPTH_BITWIDTH;
  localparam logic [31:0] A_LEDS = TOP_ADDR;
  localparam logic [31:0] A_OUT  = TOP_ADDR - 32'd1;
  localparam logic [31:0] A_IN   = TOP_ADDR - 32'd2;
  localparam logic [31:0] A_STAT = TOP_ADDR - 32'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_SEND, TX_ACK} tx_state_t;

  tx_state_t            tx_st_q, tx_st_d;
  logic                 tx_go_q, tx_go_d, tx_bsy, tx_pop, tx_push, tx_drop;
  logic [7:0]           tx_mem [1 << TXB];
  logic [TXB:0]         tx_wr_q, tx_rd_q;
  logic [7:0]           tx_data_q, tx_last_q;
  logic                 tx_full, tx_empty, tx_idle, tx_ovf_q;
  logic [7:0]           rx_mem [1 << RXB];
  logic [RXB:0]         rx_wr_q, rx_rd_q;
  logic                 rx_go_q, rx_dr, rx_evt, rx_push, rx_pop, rx_full, rx_empty, rx_ovf_q;
  logic [7:0]           rx_data;
  logic [LED_WIDTH-1:0] leds_q;
  logic [31:0]          dout_q;
  logic                 rd_v, wr_v, stat_clr;
  logic [7:0]           status;
  logic                 unused_din;

  assign unused_din = ^din[31:8];
  assign hit  = (addr == A_LEDS) || (addr == A_OUT) || (addr == A_IN) || (addr == A_STAT);
  assign rd_v = hit && (re == 3'b001);
  assign wr_v = hit && (we == 2'b01);

  assign tx_full  = (tx_wr_q[TXB] != tx_rd_q[TXB]) && (tx_wr_q[TXB-1:0] == tx_rd_q[TXB-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_idle  = tx_empty && (tx_st_q == TX_IDLE);
  assign tx_push  = wr_v && (addr == A_OUT) && (!tx_full || tx_pop);
  assign tx_drop  = wr_v && (addr == A_OUT) && tx_full && !tx_pop;

  assign rx_full  = (rx_wr_q[RXB] != rx_rd_q[RXB]) && (rx_wr_q[RXB-1:0] == rx_rd_q[RXB-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_evt   = rx_dr && rx_go_q;
  assign rx_push  = rx_evt && !rx_full;
  assign rx_pop   = rd_v && (addr == A_IN) && !rx_empty;
  assign stat_clr = wr_v && (addr == A_STAT);
  assign status   = {3'b000, tx_idle, tx_ovf_q, rx_ovf_q, tx_full, !rx_empty};

  always_comb begin
    tx_st_d = tx_st_q;
    tx_go_d = tx_go_q;
    tx_pop  = 1'b0;
    case (tx_st_q)
      TX_IDLE: if (!tx_empty && !tx_bsy) begin
        tx_pop  = 1'b1;
        tx_go_d = 1'b1;
        tx_st_d = TX_START;
      end
      TX_START: if (tx_bsy) tx_st_d = TX_SEND;
      TX_SEND: if (!tx_bsy) begin
        tx_go_d = 1'b0;
        tx_st_d = TX_ACK;
      end
      TX_ACK:  tx_st_d = TX_IDLE;
      default: tx_st_d = TX_IDLE;
    endcase
  end

  // Storage arrays carry no reset; resetting the pointers discards their contents
  always_ff @(posedge clk_cpu) begin
    if (tx_push) tx_mem[tx_wr_q[TXB-1:0]] <= din[7:0];
    if (tx_pop)  tx_data_q <= tx_mem[tx_rd_q[TXB-1:0]];
    if (rx_push) rx_mem[rx_wr_q[RXB-1:0]] <= rx_data;
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      tx_st_q   <= TX_IDLE;
      tx_go_q   <= 1'b0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_last_q <= '0;
      tx_ovf_q  <= 1'b0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_go_q   <= 1'b1;
      rx_ovf_q  <= 1'b0;
      leds_q    <= '1;
      dout_q    <= '0;
    end else begin
      tx_st_q <= tx_st_d;
      tx_go_q <= tx_go_d;
      rx_go_q <= !rx_evt;
      if (tx_push) begin
        tx_wr_q   <= tx_wr_q + 1'b1;
        tx_last_q <= din[7:0];
      end
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      // Set events outrank a same-cycle clear
      tx_ovf_q <= tx_drop | (tx_ovf_q & ~(stat_clr & din[3]));
      rx_ovf_q <= (rx_evt & rx_full) | (rx_ovf_q & ~(stat_clr & din[2]));
      if (wr_v && addr == A_LEDS) leds_q <= din[LED_WIDTH-1:0];
      dout_q <= '0;
      if (rd_v) begin
        case (addr)
          A_LEDS:  dout_q <= 32'(leds_q);
          A_OUT:   dout_q <= 32'(tx_last_q);
          A_IN:    dout_q <= rx_empty ? 32'd0 : 32'(rx_mem[rx_rd_q[RXB-1:0]]);
          A_STAT:  dout_q <= 32'(status);
          default: dout_q <= '0;
        endcase
      end
    end
  end

  mmio_uart_tx #(.CPB(CPB)) u_tx (
    .clk_cpu(clk_cpu), .rst(rst), .go(tx_go_q), .data(tx_data_q), .bsy(tx_bsy), .tx(uart_tx)
  );

  mmio_uart_rx #(.CPB(CPB)) u_rx (
    .clk_cpu(clk_cpu), .rst(rst), .rx(uart_rx), .go(rx_go_q), .dr(rx_dr), .data(rx_data)
  );

  assign dout     = dout_q;
  assign leds     = leds_q;
  assign rx_ready = !rx_empty;
endmodule
